seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Scan controller for the 4-digit common-anode seven-segment display. Holds four
//  4-bit digit registers, accepts digit writes over a valid/ready port and
//  time-multiplexes the digits onto shared segment lines with a blanking gap.
//  Writes are committed only during blanking, so a digit never changes mid-slot.
//  Sits between the user/control logic and the board's seg/anode pins.
// PARAMETERS
//  REFRESH_DIV  50000  clock cycles per digit slot (blank + show); must be > BLANK_CYC
//  BLANK_CYC    16     cycles at the start of each slot with all anodes off; >= 1
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  en         in   1  display enable; 0 = all digits dark, scan held
//  wr_valid   in   1  write request
//  wr_ready   out  1  write accepted when wr_valid & wr_ready on a rising edge
//  wr_sel     in   2  digit index to write (0 = rightmost, an[0])
//  wr_data    in   4  hex value for that digit
//  seg        out  7  segments, active-low, seg[0]=a .. seg[6]=g
//  an         out  4  digit anodes, active-low, one-hot-low while showing
//  scan_tick  out  1  one-cycle pulse at the start of each full 4-digit frame
// BEHAVIOUR
//  Reset (async): digits all 0, state IDLE, idx 0, slot counter 0, no pending
//   write, wr_ready=1, an=4'hF, seg=7'h7F, scan_tick=0. All outputs registered.
//  Write staging: on accept, {wr_sel,wr_data} latched into a one-entry stage,
//   wr_ready drops the next cycle and stays low until the stage commits.
//   Commit writes the digit register; wr_ready returns high the cycle after.
//  Commit point: first cycle of a BLANK phase, or the cycle after accept if in
//   IDLE. Worst-case accept-to-commit latency REFRESH_DIV cycles while scanning.
//  FSM (states IDLE, BLANK, SHOW; slot counter cnt, digit index idx 0..3):
//   IDLE : an=F, seg=7F, cnt=0, idx=0. en=1 -> BLANK (idx 0).
//   BLANK: an=F, seg=7F; lasts BLANK_CYC cycles (cnt 0..BLANK_CYC-1) -> SHOW.
//   SHOW : an[idx]=0, others 1; seg=decode(digit[idx]); lasts
//          REFRESH_DIV-BLANK_CYC cycles; then cnt=0, idx=idx+1 mod 4 -> BLANK.
//   en=0 in any state -> IDLE next cycle (outputs dark that cycle onward).
//   an/seg take the new state's values in the same cycle the state register does.
//  scan_tick=1 for exactly the first BLANK cycle of idx 0, including the first
//   BLANK after IDLE; 0 otherwise.
//  Decode (hex, active-low, {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//   8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Simultaneous: accept and commit cannot coincide (stage is one entry). A
//   commit to digit idx in BLANK is visible in the SHOW that follows.
//  Reset mid-operation: pending write discarded, all state to reset values.
// TESTING (bench params REFRESH_DIV=8, BLANK_CYC=2)
//  1 Reset asserted mid-SHOW -> an=F, seg=7F, wr_ready=1 immediately; digits 0.
//  2 en=0, write sel=2 data=A -> wr_ready low 1 cycle; then en=1 shows digit2
//    seg=08 on an=1011 in its slot, other digits seg=40.
//  3 en=1 from IDLE -> an: F,F, then 1110 x6, F,F, 1101 x6, ...; scan_tick
//    high on 1st cycle after en and every 32 cycles.
//  4 Write sel=0 data=5 during SHOW of idx 0 -> seg stays 40 to slot end,
//    commit at next BLANK; wr_ready low until then; next idx-0 SHOW seg=12.
//  5 Back-to-back writes held valid -> second accepted only after first commits,
//    one per slot; both values displayed correctly.
//  6 en dropped mid-SHOW of idx 2 -> next cycle an=F; re-enable restarts at idx 0
//    with BLANK and scan_tick pulse.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: digit-write valid/ready port of the seven-segment scan controller
interface seg7_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_sel;
  logic [3:0] wr_data;
  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode seven-segment scanner with blanking and a one-entry write stage
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  seg7_scan_ctrl_if.slave        wr,
  output logic [6:0]             seg_o,
  output logic [3:0]             an_o,
  output logic                   scan_tick_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            pend_q, pend_d;
  logic [1:0]      psel_q, psel_d;
  logic [3:0]      pdata_q, pdata_d;
  logic            ready_q, ready_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            tick_q, tick_d;
  logic            commit, accept;
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction
  // Digits only change while dark: in IDLE or on the first cycle of a blanking gap.
  assign commit = pend_q && (state_q == IDLE || (state_q == BLANK && cnt_q == '0));
  assign accept = wr.wr_valid && ready_q;
  always_comb begin
    dig_d   = dig_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    pdata_d = pdata_q;
    if (commit) begin
      dig_d[psel_q] = pdata_q;
      pend_d        = 1'b0;
    end
    if (accept) begin
      pend_d  = 1'b1;
      psel_d  = wr.wr_sel;
      pdata_d = wr.wr_data;
    end
    ready_d = !pend_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
        BLANK: begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(BLANK_CYC - 1)) ? SHOW : BLANK;
        end
        SHOW: begin
          state_d = (cnt_q == CW'(REFRESH_DIV - 1)) ? BLANK : SHOW;
          cnt_d   = (cnt_q == CW'(REFRESH_DIV - 1)) ? '0 : cnt_q + CW'(1);
          idx_d   = (cnt_q == CW'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end
  // Outputs are registered from the next state so they track the state register.
  always_comb begin
    an_d   = (state_d == SHOW) ? ~(4'b0001 << idx_d) : 4'hF;
    seg_d  = (state_d == SHOW) ? decode(dig_d[idx_d]) : 7'h7F;
    tick_d = (state_d == BLANK) && (cnt_d == '0) && (idx_d == 2'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      dig_q   <= '0;
      pend_q  <= 1'b0;
      psel_q  <= 2'd0;
      pdata_q <= 4'd0;
      ready_q <= 1'b1;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      pend_q  <= pend_d;
      psel_q  <= psel_d;
      pdata_q <= pdata_d;
      ready_q <= ready_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end
  assign wr.wr_ready  = ready_q;
  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign scan_tick_o  = tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed plus random stimulus against a time-since-enable display model
module tb_seg7_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       tick;
  seg7_scan_ctrl_if bus();
  seg7_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .wr(bus.slave),
    .seg_o(seg), .an_o(an), .scan_tick_o(tick)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // Model: m_t counts cycles since the scan (re)started; slot, digit and phase follow by arithmetic.
  bit         m_run;
  int         m_t;
  logic [3:0] m_dig [4];
  bit         m_pend;
  logic [1:0] m_psel;
  logic [3:0] m_pdata;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_run = 0;
    m_t = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_pend = 0;
  endtask
  task automatic m_step();
    bit do_commit, do_accept;
    do_commit = m_pend && (!m_run || (m_t % RD) == 0);
    do_accept = bus.wr_valid && !m_pend;
    if (do_commit) begin
      m_dig[m_psel] = m_pdata;
      m_pend = 0;
    end
    if (do_accept) begin
      m_pend = 1;
      m_psel = bus.wr_sel;
      m_pdata = bus.wr_data;
    end
    if (!en) begin
      m_run = 0;
      m_t = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t = 0;
    end else m_t++;
  endtask
  function automatic int cur_idx();
    return (m_t / RD) % 4;
  endfunction
  function automatic bit showing();
    return m_run && (m_t % RD) >= BC;
  endfunction
  task automatic check_all();
    logic [3:0] ea;
    logic [6:0] es;
    ea = 4'hF;
    es = 7'h7F;
    if (showing()) begin
      ea = ~(4'b0001 << cur_idx());
      es = dec[m_dig[cur_idx()]];
    end
    chk("an", 8'(an), 8'(ea));
    chk("seg", 8'(seg), 8'(es));
    chk("wr_ready", 8'(bus.wr_ready), 8'(!m_pend));
    chk("scan_tick", 8'(tick), 8'(m_run && (m_t % (4 * RD)) == 0));
  endtask
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step();
    #1 check_all();
  endtask
  task automatic wait_show(input int idx, input int minpos);
    for (int k = 0; k < 200; k++) begin
      if (m_run && cur_idx() == idx && (m_t % RD) >= minpos) return;
      cyc();
    end
    chk("wait_show_timeout", 8'd0, 8'd1);
  endtask
  task automatic write(input logic [1:0] sel, input logic [3:0] data);
    bit got;
    bus.wr_valid = 1'b1;
    bus.wr_sel = sel;
    bus.wr_data = data;
    for (int k = 0; k < 100; k++) begin
      got = bus.wr_ready;
      cyc();
      if (got) begin
        bus.wr_valid = 1'b0;
        return;
      end
    end
    bus.wr_valid = 1'b0;
    chk("write_timeout", 8'd0, 8'd1);
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_sel = 2'd0;
    bus.wr_data = 4'd0;
    m_reset();
    run(3);
    rst_n = 1'b1;
    run(2);
    write(2'd2, 4'hA);
    run(3);
    en = 1'b1;
    cyc();
    chk("first_tick", 8'(tick), 8'd1);
    wait_show(2, BC);
    chk("digit2_seg", 8'(seg), 8'h08);
    chk("digit2_an", 8'(an), 8'hB);
    run(40);
    wait_show(1, BC + 1);
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_all();
    cyc();
    rst_n = 1'b1;
    run(3);
    en = 1'b1;
    wait_show(0, BC + 1);
    write(2'd0, 4'h5);
    chk("seg_holds_mid_slot", 8'(seg), 8'h40);
    run(40);
    wait_show(0, BC);
    chk("digit0_seg", 8'(seg), 8'h12);
    write(2'd1, 4'h7);
    write(2'd3, 4'hE);
    run(70);
    wait_show(2, BC + 1);
    en = 1'b0;
    cyc();
    chk("drop_an", 8'(an), 8'hF);
    run(3);
    en = 1'b1;
    cyc();
    chk("restart_tick", 8'(tick), 8'd1);
    run(40);
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom % 60) != 0;
      bus.wr_valid = ($urandom % 4) == 0;
      bus.wr_sel = 2'($urandom);
      bus.wr_data = 4'($urandom);
      rst_n = ($urandom % 500) != 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
